// File: rtl/trng_pkg.sv
// Shared constants for the TRNG register bank: register map, ISR bit
// positions, debug_ctrl bit positions and register reset values.
package trng_pkg;

    // APB address width and register payload widths
    localparam int unsigned APB_AW = 12;
    localparam int unsigned ISR_W  = 4;
    localparam int unsigned DBG_W  = 4;

    // Register map (byte addresses)
    localparam logic [APB_AW-1:0] ADDR_IMR        = 12'h100;
    localparam logic [APB_AW-1:0] ADDR_ISR        = 12'h104;
    localparam logic [APB_AW-1:0] ADDR_ICR        = 12'h108;
    localparam logic [APB_AW-1:0] ADDR_CONFIG     = 12'h10C;
    localparam logic [APB_AW-1:0] ADDR_VALID      = 12'h110;
    localparam logic [APB_AW-1:0] ADDR_EHR_DATA0  = 12'h114;
    localparam logic [APB_AW-1:0] ADDR_SRC_EN     = 12'h12C;
    localparam logic [APB_AW-1:0] ADDR_SAMPLE_CNT = 12'h130;
    localparam logic [APB_AW-1:0] ADDR_TMO_LIMIT  = 12'h134;
    localparam logic [APB_AW-1:0] ADDR_DEBUG_CTRL = 12'h138;
    localparam logic [APB_AW-1:0] ADDR_RST_BITS   = 12'h140;

    // ISR bit indices
    localparam int unsigned ISR_EHR_VALID = 0;
    localparam int unsigned ISR_AUTOCORR  = 1;
    localparam int unsigned ISR_CRNGT     = 2;
    localparam int unsigned ISR_WATCHDOG  = 3;

    // debug_ctrl bit indices
    localparam int unsigned DBG_SRC_DIV         = 0;
    localparam int unsigned DBG_VNC_BYPASS      = 1;
    localparam int unsigned DBG_CRNGT_BYPASS    = 2;
    localparam int unsigned DBG_AUTOCORR_BYPASS = 3;

    // Reset values; consumers cast these to their configured widths
    localparam logic [ISR_W-1:0] IMR_RST        = 4'hF;
    localparam int unsigned      SAMPLE_CNT_RST = 1000;
    localparam logic [31:0]      TMO_LIMIT_RST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/trng_irq_ctrl.sv
// Interrupt block: mask register, status register with write-1-to-clear
// where a hardware set in the same cycle wins, and the registered irq line.
module trng_irq_ctrl
    import trng_pkg::*;
(
    input  logic             rng_clk,
    input  logic             rst_n,
    input  logic             imr_we,
    input  logic [ISR_W-1:0] imr_wdata,
    input  logic             icr_we,
    input  logic [ISR_W-1:0] icr_wdata,
    input  logic [ISR_W-1:0] isr_set,
    output logic [ISR_W-1:0] imr,
    output logic [ISR_W-1:0] isr,
    output logic             irq
);

    logic [ISR_W-1:0] isr_clr;

    // Clear vector is only live during an ICR write
    always_comb begin
        isr_clr = '0;
        if (icr_we) begin
            isr_clr = icr_wdata;
        end
    end

    // Interrupt mask register
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            imr <= IMR_RST;
        end else if (imr_we) begin
            imr <= imr_wdata;
        end
    end

    // Status register: set terms are OR'd after the clear so they win
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            isr <= '0;
        end else begin
            isr <= (isr & ~isr_clr) | isr_set;
        end
    end

    // irq follows the masked status one cycle later
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(isr & ~imr);
        end
    end

endmodule

// File: rtl/trng_reg_file_mc.sv
// TRNG register bank and control sequencer: APB register map, EHR read
// tracking, debug EHR writes, datapath reset pulse and interrupt sources.
// Optional collection watchdog is built when TRNG_WATCHDOG_EN is defined.
module trng_reg_file_mc
    import trng_pkg::*;
#(
    parameter int unsigned EHR_WORDS    = 6,
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned SAMPLE_CNT_W = 32,
    parameter int unsigned TMO_W        = 24,
    localparam int unsigned SRC_SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                    rng_clk,
    input  logic                    rst_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [APB_AW-1:0]       paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    input  logic                    rng_debug_enable,
    input  logic                    ehr_valid,
    input  logic [32*EHR_WORDS-1:0] ehr_data,
    input  logic                    autocorr_err,
    input  logic                    crngt_err,
    input  logic                    prng_busy,
    input  logic                    prng_ehr_rd,
    output logic [SRC_SEL_W-1:0]    rnd_src_sel,
    output logic                    rnd_src_en,
    output logic [SAMPLE_CNT_W-1:0] sample_cnt,
    output logic [DBG_W-1:0]        debug_ctrl,
    output logic                    trng_valid,
    output logic                    cpu_ehr_wr,
    output logic [2:0]              cpu_ehr_wr_idx,
    output logic                    rst_trng_logic,
    output logic                    trng_busy,
    output logic                    irq
);

    logic                 wr_acc;
    logic                 rd_acc;
    logic [APB_AW-1:0]    ehr_off;
    logic [APB_AW-3:0]    ehr_word_sel;
    logic [2:0]           ehr_idx;
    logic                 fixed_hit;
    logic                 ehr_sel;
    logic                 ehr_rd_ok;
    logic                 ehr_cpu_rd;
    logic                 ehr_dbg_wr;
    logic                 ehr_last_wr;
    logic [31:0]          ehr_rd_word;
    logic [EHR_WORDS-1:0] rd_mask;
    logic [EHR_WORDS-1:0] rd_mask_set;
    logic                 rd_mask_full;
    logic                 we_imr;
    logic                 we_icr;
    logic                 we_config;
    logic                 we_src_en;
    logic                 we_sample_cnt;
    logic                 we_tmo_limit;
    logic                 we_debug_ctrl;
    logic                 we_rst_bits;
    logic [SRC_SEL_W-1:0] trng_config;
    logic                 src_en_d;
    logic                 trng_valid_d;
    logic                 tmo_hit;
    logic [31:0]          tmo_limit_rd;
    logic [ISR_W-1:0]     isr_set;
    logic [ISR_W-1:0]     imr;
    logic [ISR_W-1:0]     isr;

    // APB access qualification and address decode
    assign wr_acc       = psel & penable & pwrite;
    assign rd_acc       = psel & penable & ~pwrite;
    assign ehr_off      = paddr - ADDR_EHR_DATA0;
    assign ehr_word_sel = ehr_off[APB_AW-1:2];
    assign ehr_idx      = ehr_word_sel[2:0];
    assign fixed_hit    = paddr inside {ADDR_IMR, ADDR_ISR, ADDR_ICR, ADDR_CONFIG,
                                        ADDR_VALID, ADDR_SRC_EN, ADDR_SAMPLE_CNT,
                                        ADDR_TMO_LIMIT, ADDR_DEBUG_CTRL, ADDR_RST_BITS};
    assign ehr_sel      = (paddr >= ADDR_EHR_DATA0) && (ehr_off[1:0] == 2'b00) &&
                          (ehr_word_sel < (APB_AW-2)'(EHR_WORDS)) && !fixed_hit;

    assign we_imr        = wr_acc & (paddr == ADDR_IMR);
    assign we_icr        = wr_acc & (paddr == ADDR_ICR);
    assign we_config     = wr_acc & (paddr == ADDR_CONFIG);
    assign we_src_en     = wr_acc & (paddr == ADDR_SRC_EN);
    assign we_sample_cnt = wr_acc & (paddr == ADDR_SAMPLE_CNT);
    assign we_tmo_limit  = wr_acc & (paddr == ADDR_TMO_LIMIT);
    assign we_debug_ctrl = wr_acc & (paddr == ADDR_DEBUG_CTRL);
    assign we_rst_bits   = wr_acc & (paddr == ADDR_RST_BITS);

    // EHR access qualification: CPU reads only outside debug and PRNG ownership
    assign ehr_rd_ok    = trng_valid & ~prng_busy & ~rng_debug_enable;
    assign ehr_cpu_rd   = rd_acc & ehr_sel & ehr_rd_ok;
    assign ehr_dbg_wr   = wr_acc & ehr_sel & rng_debug_enable & ~rnd_src_en & ~trng_valid;
    assign ehr_last_wr  = ehr_dbg_wr & (ehr_idx == 3'(EHR_WORDS-1));
    assign rd_mask_full = &rd_mask;

    // Select the addressed EHR word and its read-tracking bit
    always_comb begin
        ehr_rd_word = '0;
        rd_mask_set = '0;
        for (int i = 0; i < EHR_WORDS; i++) begin
            if (ehr_idx == 3'(i)) begin
                ehr_rd_word    = ehr_data[32*i +: 32];
                rd_mask_set[i] = ehr_cpu_rd;
            end
        end
    end

    // Read data mux; fixed registers take precedence over the EHR window
    always_comb begin
        prdata = '0;
        case (paddr)
            ADDR_IMR:        prdata = 32'(imr);
            ADDR_ISR:        prdata = 32'(isr);
            ADDR_CONFIG:     prdata = 32'(trng_config);
            ADDR_VALID:      prdata = 32'(trng_valid);
            ADDR_SRC_EN:     prdata = 32'(rnd_src_en);
            ADDR_SAMPLE_CNT: prdata = 32'(sample_cnt);
            ADDR_TMO_LIMIT:  prdata = tmo_limit_rd;
            ADDR_DEBUG_CTRL: prdata = 32'(debug_ctrl);
            default: begin
                if (ehr_sel && ehr_rd_ok) begin
                    prdata = ehr_rd_word;
                end
            end
        endcase
    end

    // Source select configuration
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_config <= '0;
        end else if (we_config) begin
            trng_config <= pwdata[SRC_SEL_W-1:0];
        end
    end
    assign rnd_src_sel = trng_config;

    // Source enable; an autocorrelation failure overrides a CPU write
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_src_en <= 1'b0;
        end else if (autocorr_err) begin
            rnd_src_en <= 1'b0;
        end else if (we_src_en) begin
            rnd_src_en <= pwdata[0];
        end
    end

    // Sampling period
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= SAMPLE_CNT_W'(SAMPLE_CNT_RST);
        end else if (we_sample_cnt) begin
            sample_cnt <= pwdata[SAMPLE_CNT_W-1:0];
        end
    end

    // Debug datapath controls, writable only in the debug lifecycle state
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            debug_ctrl <= '0;
        end else if (we_debug_ctrl && rng_debug_enable) begin
            debug_ctrl[DBG_SRC_DIV]         <= pwdata[DBG_SRC_DIV];
            debug_ctrl[DBG_VNC_BYPASS]      <= pwdata[DBG_VNC_BYPASS];
            debug_ctrl[DBG_CRNGT_BYPASS]    <= pwdata[DBG_CRNGT_BYPASS];
            debug_ctrl[DBG_AUTOCORR_BYPASS] <= pwdata[DBG_AUTOCORR_BYPASS];
        end
    end

    // Edge-detect history; src_en_d resets high so reset exit is not an edge
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            src_en_d     <= 1'b1;
            trng_valid_d <= 1'b0;
        end else begin
            src_en_d     <= rnd_src_en;
            trng_valid_d <= trng_valid;
        end
    end

    // Datapath reset pulse
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_trng_logic <= 1'b0;
        end else begin
            rst_trng_logic <= (rnd_src_en & ~src_en_d) | we_sample_cnt |
                              (we_rst_bits & rng_debug_enable & ~rnd_src_en);
        end
    end

    // EHR valid flag; any clear source beats a set in the same cycle
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            trng_valid <= 1'b0;
        end else if (prng_ehr_rd || rst_trng_logic || rd_mask_full) begin
            trng_valid <= 1'b0;
        end else if (ehr_valid || ehr_last_wr) begin
            trng_valid <= 1'b1;
        end
    end

    // Order-independent tracking of which EHR words the CPU has consumed
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_mask <= '0;
        end else if (rst_trng_logic || rd_mask_full) begin
            rd_mask <= '0;
        end else begin
            rd_mask <= rd_mask | rd_mask_set;
        end
    end

    // Debug EHR write strobe and word index
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ehr_wr     <= 1'b0;
            cpu_ehr_wr_idx <= '0;
        end else begin
            cpu_ehr_wr <= ehr_dbg_wr;
            if (ehr_dbg_wr) begin
                cpu_ehr_wr_idx <= ehr_idx;
            end
        end
    end

    assign trng_busy = rnd_src_en & ~trng_valid & ~ehr_valid;

`ifdef TRNG_WATCHDOG_EN
    logic [TMO_W-1:0] tmo_limit;
    logic [TMO_W-1:0] tmo_cnt;

    // Watchdog limit register
    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_limit <= TMO_W'(TMO_LIMIT_RST);
        end else if (we_tmo_limit) begin
            tmo_limit <= pwdata[TMO_W-1:0];
        end
    end

    // Collection watchdog; restarts from 0 on reaching the limit
    assign tmo_hit      = rnd_src_en & ~trng_valid & (tmo_cnt >= tmo_limit);
    assign tmo_limit_rd = 32'(tmo_limit);

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (!rnd_src_en || trng_valid || rst_trng_logic || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`else
    logic unused_tmo_we;

    assign unused_tmo_we = we_tmo_limit;
    assign tmo_hit       = 1'b0;
    assign tmo_limit_rd  = 32'({TMO_W{1'b0}});
`endif

    // Interrupt sources, each captured as a one-cycle set request
    always_comb begin
        isr_set               = '0;
        isr_set[ISR_EHR_VALID] = trng_valid & ~trng_valid_d;
        isr_set[ISR_AUTOCORR]  = autocorr_err;
        isr_set[ISR_CRNGT]     = crngt_err;
        isr_set[ISR_WATCHDOG]  = tmo_hit;
    end

    trng_irq_ctrl u_irq_ctrl (
        .rng_clk   (rng_clk),
        .rst_n     (rst_n),
        .imr_we    (we_imr),
        .imr_wdata (pwdata[ISR_W-1:0]),
        .icr_we    (we_icr),
        .icr_wdata (pwdata[ISR_W-1:0]),
        .isr_set   (isr_set),
        .imr       (imr),
        .isr       (isr),
        .irq       (irq)
    );

endmodule

// File: tb/tb_trng_reg_file_mc.sv
// Directed bench for trng_reg_file_mc (default parameters). Build with
// TRNG_WATCHDOG_EN defined to exercise the watchdog timing branch.
module tb_trng_reg_file_mc;

    localparam int unsigned EHR_WORDS = 6;

    localparam logic [11:0] A_IMR    = 12'h100;
    localparam logic [11:0] A_ISR    = 12'h104;
    localparam logic [11:0] A_ICR    = 12'h108;
    localparam logic [11:0] A_CONFIG = 12'h10C;
    localparam logic [11:0] A_VALID  = 12'h110;
    localparam logic [11:0] A_EHR0   = 12'h114;
    localparam logic [11:0] A_SRCEN  = 12'h12C;
    localparam logic [11:0] A_SCNT   = 12'h130;
    localparam logic [11:0] A_TMO    = 12'h134;
    localparam logic [11:0] A_DBG    = 12'h138;
    localparam logic [11:0] A_RSTB   = 12'h140;

    logic                    rng_clk;
    logic                    rst_n;
    logic                    psel, penable, pwrite;
    logic [11:0]             paddr;
    logic [31:0]             pwdata;
    logic [31:0]             prdata;
    logic                    rng_debug_enable;
    logic                    ehr_valid;
    logic [32*EHR_WORDS-1:0] ehr_data;
    logic                    autocorr_err, crngt_err;
    logic                    prng_busy, prng_ehr_rd;
    logic [1:0]              rnd_src_sel;
    logic                    rnd_src_en;
    logic [31:0]             sample_cnt;
    logic [3:0]              debug_ctrl;
    logic                    trng_valid;
    logic                    cpu_ehr_wr;
    logic [2:0]              cpu_ehr_wr_idx;
    logic                    rst_trng_logic;
    logic                    trng_busy;
    logic                    irq;

    int total = 0;
    int bad   = 0;

    trng_reg_file_mc #(
        .EHR_WORDS    (6),
        .NUM_SRC      (4),
        .SAMPLE_CNT_W (32),
        .TMO_W        (24)
    ) dut (
        .rng_clk          (rng_clk),
        .rst_n            (rst_n),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .prdata           (prdata),
        .rng_debug_enable (rng_debug_enable),
        .ehr_valid        (ehr_valid),
        .ehr_data         (ehr_data),
        .autocorr_err     (autocorr_err),
        .crngt_err        (crngt_err),
        .prng_busy        (prng_busy),
        .prng_ehr_rd      (prng_ehr_rd),
        .rnd_src_sel      (rnd_src_sel),
        .rnd_src_en       (rnd_src_en),
        .sample_cnt       (sample_cnt),
        .debug_ctrl       (debug_ctrl),
        .trng_valid       (trng_valid),
        .cpu_ehr_wr       (cpu_ehr_wr),
        .cpu_ehr_wr_idx   (cpu_ehr_wr_idx),
        .rst_trng_logic   (rst_trng_logic),
        .trng_busy        (trng_busy),
        .irq              (irq)
    );

    initial begin
        rng_clk = 1'b0;
        forever #5 rng_clk = ~rng_clk;
    end

    function automatic logic [31:0] ew(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rng_clk);
        #1;
    endtask

    // Write with optional error pulses asserted in the access cycle
    task automatic apb_write_ev(input logic [11:0] a, input logic [31:0] d,
                                input logic ac, input logic cr);
        @(negedge rng_clk);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        @(negedge rng_clk);
        penable = 1'b1; autocorr_err = ac; crngt_err = cr;
        @(posedge rng_clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        autocorr_err = 1'b0; crngt_err = 1'b0;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        apb_write_ev(a, d, 1'b0, 1'b0);
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge rng_clk);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(negedge rng_clk);
        penable = 1'b1;
        #1;
        d = prdata;
        @(posedge rng_clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int order [6];

        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        rng_debug_enable = 1'b0; ehr_valid = 1'b0;
        autocorr_err = 1'b0; crngt_err = 1'b0; prng_busy = 1'b0; prng_ehr_rd = 1'b0;
        for (int i = 0; i < EHR_WORDS; i++) ehr_data[32*i +: 32] = ew(i);
        order = '{5, 0, 3, 3, 1, 2};

        // Reset state
        repeat (2) @(negedge rng_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_rst_pulse_after_reset", rst_trng_logic, 0);
        end
        check("sample_cnt_rst", sample_cnt, 32'd1000);
        check("irq_rst", irq, 0);
        check("valid_rst", trng_valid, 0);
        check("src_en_rst", rnd_src_en, 0);
        check("dbg_rst", debug_ctrl, 0);
        apb_read(A_IMR, rd);
        check("imr_rst", rd, 32'hF);
`ifdef TRNG_WATCHDOG_EN
        apb_read(A_TMO, rd);
        check("tmo_limit_rst", rd, 32'h00FF_FFFF);
`endif

        // Source enable produces a single datapath reset pulse
        apb_write(A_SRCEN, 32'h1);
        check("src_en_set", rnd_src_en, 1);
        check("rst_pulse_pre", rst_trng_logic, 0);
        tick();
        check("rst_pulse_hi", rst_trng_logic, 1);
        tick();
        check("rst_pulse_lo", rst_trng_logic, 0);
        check("busy_collecting", trng_busy, 1);

        // EHR fill
        @(negedge rng_clk);
        ehr_valid = 1'b1;
        tick();
        ehr_valid = 1'b0;
        check("valid_set", trng_valid, 1);
        check("busy_when_valid", trng_busy, 0);
        apb_read(A_ISR, rd);
        check("isr_ehr_valid", rd, 32'h1);
        check("irq_masked", irq, 0);

        // Reads blocked while PRNG owns the EHR
        prng_busy = 1'b1;
        apb_read(A_EHR0, rd);
        check("rd_prng_busy", rd, 0);
        prng_busy = 1'b0;

        // Out-of-order and repeated reads do not complete the mask
        for (int k = 0; k < 6; k++) begin
            apb_read(A_EHR0 + 12'(4 * order[k]), rd);
            check("ehr_rd_data", rd, ew(order[k]));
            check("valid_hold", trng_valid, 1);
        end
        apb_read(A_EHR0 + 12'd16, rd);
        check("ehr_rd_word4", rd, ew(4));
        check("valid_mask_full_same", trng_valid, 1);
        tick();
        check("valid_mask_clr", trng_valid, 0);
        apb_read(A_EHR0 + 12'd4, rd);
        check("rd_not_valid", rd, 0);

        // PRNG consumption clears valid
        @(negedge rng_clk);
        ehr_valid = 1'b1;
        tick();
        ehr_valid = 1'b0;
        check("valid_set2", trng_valid, 1);
        @(negedge rng_clk);
        prng_ehr_rd = 1'b1;
        tick();
        prng_ehr_rd = 1'b0;
        check("valid_prng_clr", trng_valid, 0);

        // Debug EHR writes with the source disabled
        apb_write(A_SRCEN, 32'h0);
        rng_debug_enable = 1'b1;
        for (int i = 0; i < EHR_WORDS; i++) begin
            apb_write(A_EHR0 + 12'(4 * i), 32'h1234_0000 + 32'(i));
            check("dbg_wr_strobe", cpu_ehr_wr, 1);
            check("dbg_wr_idx", cpu_ehr_wr_idx, 32'(i));
            check("dbg_wr_valid", trng_valid, (i == EHR_WORDS - 1) ? 1 : 0);
        end
        tick();
        check("dbg_wr_strobe_lo", cpu_ehr_wr, 0);
        apb_read(A_EHR0, rd);
        check("rd_debug_zero", rd, 0);
        apb_read(A_VALID, rd);
        check("valid_reg", rd, 32'h1);
        apb_write(A_DBG, 32'hA);
        check("debug_ctrl", debug_ctrl, 32'hA);
        apb_write(A_RSTB, 32'h1);
        check("rstbits_pulse", rst_trng_logic, 1);
        tick();
        check("rstbits_pulse_lo", rst_trng_logic, 0);
        check("rstbits_valid_clr", trng_valid, 0);
        rng_debug_enable = 1'b0;

        // Interrupt block
        apb_write(A_ICR, 32'hF);
        apb_write(A_IMR, 32'h0);
        tick();
        check("irq_clear_start", irq, 0);
        apb_write(A_SRCEN, 32'h1);
        check("src_en_on", rnd_src_en, 1);
        @(negedge rng_clk);
        autocorr_err = 1'b1;
        tick();
        autocorr_err = 1'b0;
        check("autocorr_src_off", rnd_src_en, 0);
        check("irq_lag", irq, 0);
        tick();
        check("irq_autocorr", irq, 1);
        apb_read(A_ISR, rd);
        check("isr_autocorr", rd, 32'h2);
        apb_write(A_SRCEN, 32'h1);
        check("src_en_on2", rnd_src_en, 1);
        apb_write_ev(A_SRCEN, 32'h1, 1'b1, 1'b0);
        check("autocorr_beats_write", rnd_src_en, 0);
        apb_write_ev(A_ICR, 32'h2, 1'b1, 1'b0);
        apb_read(A_ISR, rd);
        check("isr_set_beats_clr", rd, 32'h2);
        apb_write(A_ICR, 32'h2);
        apb_read(A_ISR, rd);
        check("isr_icr_clr", rd, 32'h0);
        check("irq_after_clr", irq, 0);
        @(negedge rng_clk);
        crngt_err = 1'b1;
        tick();
        crngt_err = 1'b0;
        apb_read(A_ISR, rd);
        check("isr_crngt", rd, 32'h4);
        apb_write(A_ICR, 32'hF);

        // Sample count and config
        apb_write(A_SCNT, 32'h0000_1234);
        check("scnt_rst_pulse", rst_trng_logic, 1);
        check("scnt_val", sample_cnt, 32'h1234);
        apb_write(A_CONFIG, 32'h7);
        check("src_sel", rnd_src_sel, 32'h3);
        apb_read(A_CONFIG, rd);
        check("config_rd", rd, 32'h3);

        // Watchdog
        apb_write(A_ICR, 32'hF);
        apb_write(A_TMO, 32'd100);
        apb_read(A_TMO, rd);
`ifdef TRNG_WATCHDOG_EN
        check("tmo_limit_rd", rd, 32'd100);
        apb_write(A_SRCEN, 32'h1);
        // Counter is at 0 after the enable reset pulse (2 edges after the
        // write) and takes 101 cycles to reach the limit and set ISR[3].
        repeat (103) tick();
        check("tmo_irq_not_yet", irq, 0);
        tick();
        check("tmo_irq", irq, 1);
        apb_read(A_ISR, rd);
        check("isr_tmo", rd, 32'h8);
`else
        check("tmo_limit_rd_off", rd, 32'h0);
        apb_write(A_SRCEN, 32'h1);
        repeat (150) tick();
        check("no_tmo_irq", irq, 0);
        apb_read(A_ISR, rd);
        check("isr_no_tmo", rd, 32'h0);
`endif
        apb_write(A_SRCEN, 32'h0);

        // Reset mid-sequence discards pending interrupts and state
        apb_write(A_ICR, 32'hF);
        @(negedge rng_clk);
        crngt_err = 1'b1;
        tick();
        crngt_err = 1'b0;
        tick();
        check("irq_before_reset", irq, 1);
        @(negedge rng_clk);
        rst_n = 1'b0;
        #2;
        check("irq_in_reset", irq, 0);
        @(negedge rng_clk);
        rst_n = 1'b1;
        tick();
        check("sample_cnt_rst2", sample_cnt, 32'd1000);
        check("rst_no_pulse2", rst_trng_logic, 0);
        apb_read(A_ISR, rd);
        check("isr_rst2", rd, 32'h0);
        apb_read(A_IMR, rd);
        check("imr_rst2", rd, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
